mips_muldiv_seq: RTL
====================

# mips_muldiv_seq

Multi-cycle sequencer for the multiply/divide path of the execute stage. It accepts one MULT/MULTU/DIV/DIVU operation at a time and latches the opcode and operands. It holds them stable on the execute-unit inputs for a programmable number of cycles, then captures the 64-bit result into the architectural HI/LO registers. It also serialises MFHI/MFLO/MTHI/MTLO against an in-flight operation by raising a pipeline stall.

## Interface
Parameters:
- MULT_LAT, 4, cycles from accept to HI/LO update for MULT/MULTU (≥1)
- DIV_LAT, 8, cycles from accept to HI/LO update for DIV/DIVU (≥1)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- md_start  in  1  request to start an operation this cycle
- md_op  in  alu_ctrl_t  ALU_MULT, ALU_MULTU, ALU_DIV or ALU_DIVU; sampled with md_start
- md_src1, md_src2  in  32 each  operands (rs, rt); sampled with md_start
- flush  in  1  cancel the in-flight operation (branch/exception kill)
- mf_req  in  1  MFHI or MFLO in decode needs HI/LO
- mthi_we, mtlo_we  in  1 each  MTHI/MTLO write request
- mt_wdata  in  32  data for MTHI/MTLO
- exu_ctrl  out  alu_ctrl_t  opcode driven to the execute unit
- exu_in1, exu_in2  out  32 each  operands driven to the execute unit
- exu_res_hi, exu_res_lo  in  32 each  execute-unit results (remainder/high, quotient/low)
- hi, lo  out  32 each  architectural HI/LO
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse when HI/LO were updated by an operation
- stall  out  1  combinational pipeline stall
- div0  out  1  one-cycle pulse when a divide by zero was detected (see Configuration)

## Operation
- FSM states: IDLE, BUSY.
- IDLE: on md_start & !flush, latch md_op, md_src1 and md_src2. Load cnt with LAT−1, where LAT is MULT_LAT for MULT/MULTU and DIV_LAT for DIV/DIVU. Go to BUSY.
- BUSY: exu_ctrl, exu_in1 and exu_in2 equal the latched values and are held constant. cnt decrements each cycle.
- BUSY with cnt==0: at that edge, hi←exu_res_hi and lo←exu_res_lo. done=1 for the next cycle. Go to IDLE.
- IDLE outputs: exu_ctrl=ALU_ADD; exu_in1=exu_in2=0.
- flush in BUSY: go to IDLE. HI/LO are unchanged and done is not pulsed.
- flush beats completion when both fall on the same edge.
- flush in IDLE together with md_start: the start is dropped.
- MTHI/MTLO in IDLE without md_start: hi (or lo) ← mt_wdata at the next edge. Both writes may occur in the same cycle.
- stall = busy & (md_start | mf_req | mthi_we | mtlo_we). While stalled, requests are not consumed and the pipeline re-presents them.
- md_start together with mthi_we/mtlo_we in IDLE: the start is accepted and the MT write is ignored. The pipeline never issues both; the bench checks only the priority.
- md_op outside the four legal values with md_start: ignored; stays IDLE.
- All widths are 32-bit. The block performs no arithmetic except the counter, which is ⌈log2(max(MULT_LAT,DIV_LAT))⌉+1 bits.

## Timing
- Reset values (async): FSM=IDLE, cnt=0, hi=lo=0, busy=done=div0=0, exu_ctrl=ALU_ADD, exu_in1=exu_in2=0. stall=0 follows from busy=0.
- busy is registered. It rises at the edge that accepts md_start and falls at the completion edge.
- Latency: start accepted at edge E0 → HI/LO updated at edge E0+LAT, done high in cycle E0+LAT.
- Back-to-back: a new md_start may be accepted in the cycle where done=1, giving one op per LAT+1 cycles.
- Reset asserted mid-operation returns every output to its reset value immediately. HI/LO contents are lost.

## Configuration
- MIPS_MD_DIV0_EN defined: DIV/DIVU with md_src2==0 is detected at accept.
  - The FSM stays IDLE and busy is not raised.
  - HI/LO are unchanged.
  - div0 pulses for one cycle after the accept edge; done is not pulsed.
- Undefined: divide by zero runs the full DIV_LAT and captures whatever exu_res_hi/lo present. div0 is tied to 0.

## Test plan
- Reset → hi=lo=0, busy=0, exu_ctrl=ALU_ADD; MULT 3×(−2) with MULT_LAT=4 → done 4 cycles after accept, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
- DIVU 17/5, DIV_LAT=8 → exu_in1/in2 held at 17/5 for 8 cycles; hi=2, lo=3; next MULTU 7×6 accepted in the done cycle → lo=42.
- mf_req and mthi_we asserted during BUSY → stall=1 each cycle until completion; mthi_we=1 with mt_wdata=32'hA5 after completion → hi=32'hA5 one edge later.
- flush on cycle 3 of a DIV → IDLE next edge, hi/lo keep their prior values, no done pulse.
- DIV 9/0 → with MIPS_MD_DIV0_EN: busy stays 0, div0 pulses, hi/lo unchanged. Without it: busy for 8 cycles, then done.
- rst_n dropped mid-MULT → all outputs at reset values asynchronously; after release, a new MULTU 2×2 gives lo=4.

Source files
------------

// File: rtl/mips_muldiv_seq.sv
// Multi-cycle sequencer for the MULT/MULTU/DIV/DIVU path: holds operands on the execute unit, then captures HI/LO.
// Optional macro MIPS_MD_DIV0_EN: reject DIV/DIVU by zero at accept and pulse div0 instead of running.

package mips_muldiv_pkg;
    typedef logic [3:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD   = 4'h0;
    localparam alu_ctrl_t ALU_MULT  = 4'h8;
    localparam alu_ctrl_t ALU_MULTU = 4'h9;
    localparam alu_ctrl_t ALU_DIV   = 4'hA;
    localparam alu_ctrl_t ALU_DIVU  = 4'hB;
endpackage

module mips_muldiv_seq
    import mips_muldiv_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        md_start,
    input  alu_ctrl_t   md_op,
    input  logic [31:0] md_src1,
    input  logic [31:0] md_src2,
    input  logic        flush,
    input  logic        mf_req,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] mt_wdata,
    output alu_ctrl_t   exu_ctrl,
    output logic [31:0] exu_in1,
    output logic [31:0] exu_in2,
    input  logic [31:0] exu_res_hi,
    input  logic [31:0] exu_res_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic        div0
);

    localparam int DATA_W  = 32;
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    alu_ctrl_t         r_exu_ctrl;
    logic [DATA_W-1:0] r_exu_in1;
    logic [DATA_W-1:0] r_exu_in2;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_done;

    logic w_idle;
    logic w_op_mul;
    logic w_op_legal;
    logic w_start_req;
    logic w_div0;
    logic w_accept;
    logic w_mt_ok;

    function automatic logic [CNT_W-1:0] f_lat_load(input alu_ctrl_t op);
        return ((op == ALU_MULT) || (op == ALU_MULTU)) ? MULT_LOAD : DIV_LOAD;
    endfunction

    assign w_idle      = (r_state == S_IDLE);
    assign w_op_mul    = (md_op == ALU_MULT) || (md_op == ALU_MULTU);
    assign w_op_legal  = w_op_mul || (md_op == ALU_DIV) || (md_op == ALU_DIVU);
    assign w_start_req = w_idle & md_start & ~flush & w_op_legal;

`ifdef MIPS_MD_DIV0_EN
    logic r_div0;

    // A zero divisor is consumed at accept without ever entering BUSY.
    assign w_div0 = w_start_req & ~w_op_mul & (md_src2 == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div0 <= 1'b0;
        end else begin
            r_div0 <= w_div0;
        end
    end

    assign div0 = r_div0;
`else
    assign w_div0 = 1'b0;
    assign div0   = 1'b0;
`endif

    assign w_accept = w_start_req & ~w_div0;
    // MT writes only land when no start competes for the same cycle.
    assign w_mt_ok  = w_idle & ~md_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_exu_ctrl <= ALU_ADD;
            r_exu_in1  <= '0;
            r_exu_in2  <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_BUSY;
                        r_cnt      <= f_lat_load(md_op);
                        r_exu_ctrl <= md_op;
                        r_exu_in1  <= md_src1;
                        r_exu_in2  <= md_src2;
                    end else begin
                        if (w_mt_ok && mthi_we) begin
                            r_hi <= mt_wdata;
                        end
                        if (w_mt_ok && mtlo_we) begin
                            r_lo <= mt_wdata;
                        end
                    end
                end
                S_BUSY: begin
                    // Flush wins over a completion falling on the same edge.
                    if (flush) begin
                        r_state    <= S_IDLE;
                        r_cnt      <= '0;
                        r_exu_ctrl <= ALU_ADD;
                        r_exu_in1  <= '0;
                        r_exu_in2  <= '0;
                    end else if (r_cnt == '0) begin
                        r_state    <= S_IDLE;
                        r_hi       <= exu_res_hi;
                        r_lo       <= exu_res_lo;
                        r_done     <= 1'b1;
                        r_exu_ctrl <= ALU_ADD;
                        r_exu_in1  <= '0;
                        r_exu_in2  <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign exu_ctrl = r_exu_ctrl;
    assign exu_in1  = r_exu_in1;
    assign exu_in2  = r_exu_in2;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = (r_state == S_BUSY);
    assign done     = r_done;
    assign stall    = busy & (md_start | mf_req | mthi_we | mtlo_we);

endmodule
